asym_tdp_ram_rf: RTL and testbench
==================================

ASYM_TDP_RAM_RF -- requirements
Module: asym_tdp_ram_rf

Interface
REQ-001 The block SHALL have parameter PORTA_DW, default 16, port A data width in bits.
REQ-002 The block SHALL have parameter PORTA_AW, default 8, port A address width (256 words).
REQ-003 The block SHALL have parameter PORTB_DW, default 4, port B data width in bits.
REQ-004 The block SHALL have parameter PORTB_AW, default 10, port B address width (1024 words).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is sampled on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port wea, input, 1 bit: port A write enable.
REQ-008 The block SHALL have port addra, input, PORTA_AW bits: port A word address.
REQ-009 The block SHALL have port dina, input, PORTA_DW bits: port A write data.
REQ-010 The block SHALL have port douta, output, PORTA_DW bits: port A read data.
REQ-011 The block SHALL have port web, input, 1 bit: port B write enable.
REQ-012 The block SHALL have port addrb, input, PORTB_AW bits: port B word address.
REQ-013 The block SHALL have port dinb, input, PORTB_DW bits: port B write data.
REQ-014 The block SHALL have port doutb, output, PORTB_DW bits: port B read data.

Function
REQ-015 Storage SHALL be one shared array of PORTA_DW*2^PORTA_AW bits, seen as 2^PORTA_AW wide words by port A and as 2^PORTB_AW narrow words by port B.
REQ-016 With RATIO = PORTA_DW/PORTB_DW and L = log2(RATIO), port B address k SHALL map to A word k>>L, lane k[L-1:0], where lane 0 is bits [PORTB_DW-1:0] (little-endian).
REQ-017 Each port SHALL read on every cycle; there is no read enable, and dout is registered with 1-cycle latency.
REQ-018 Reads SHALL be read-first: dout returns the contents before any write in the same edge, including writes by the same port.
REQ-019 A port B write SHALL modify only its lane; the other RATIO-1 lanes of that A word are unchanged.
REQ-020 On a cross-port same-edge read/write of overlapping bits, the reading port SHALL return the old data.
REQ-021 On simultaneous writes to overlapping bits, port A data SHALL win for that lane; non-overlapping bits take each port's write.
REQ-022 Elaboration SHALL fail unless PORTA_DW*2^PORTA_AW == PORTB_DW*2^PORTB_AW, PORTA_DW >= PORTB_DW, and RATIO is a power of two.

Reset
REQ-023 While rst_n=0 at a clk edge, douta and doutb SHALL be driven to 0, including any optional output pipeline stage.
REQ-024 Writes during reset SHALL still update memory; memory contents SHALL NOT be cleared by reset.
REQ-025 The first read data after reset deassertion SHALL appear at the normal latency.

Configuration
REQ-026 Macro ASYM_TDP_RAM_OUT_REG_EN, when defined, SHALL add one output register per port (read latency 2, reset to 0).
REQ-027 Without ASYM_TDP_RAM_OUT_REG_EN, read latency SHALL be 1 cycle.

Structure
REQ-028 Package asym_tdp_ram_pkg SHALL hold the default width constants and a ratio/log2 helper function.
REQ-029 The optional output stage SHALL be one sub-module, asym_tdp_ram_oreg, instantiated per port; the core array stays in asym_tdp_ram_rf.

Verification
REQ-030 Write A addr 0 = 0xAABC, then read B addr 0..3: doutb SHALL be 0xC, 0xB, 0xA, 0xA in sequence.
REQ-031 Write B addrs 64..67 = 1, 2, 3, 4, then read A addr 16: douta SHALL be 0x4321.
REQ-032 Write A addr 2 = 0x1234 over an old value of 0xCCDE: douta that cycle SHALL be 0xCCDE, and the next read SHALL return 0x1234.
REQ-033 Same edge, write A addr 5 = 0xFFFF and write B addr 20 = 0x0: word 5 SHALL read 0xFFFF.
REQ-034 Same edge, write B addr 21 = 0x7 and read A addr 5 (old value 0x0000): douta SHALL be 0x0000, and the next read SHALL return 0x0070.
REQ-035 Assert rst_n=0 mid-traffic: both outputs SHALL be 0 on the next edge, and memory data SHALL still be readable after release.

Source files
------------

// File: rtl/asym_tdp_ram_pkg.sv
// Shared constants and helpers for the asymmetric true-dual-port RAM.
// Optional output stage is enabled by defining ASYM_TDP_RAM_OUT_REG_EN.
package asym_tdp_ram_pkg;

   localparam int unsigned DEF_PORTA_DW = 16;
   localparam int unsigned DEF_PORTA_AW = 8;
   localparam int unsigned DEF_PORTB_DW = 4;
   localparam int unsigned DEF_PORTB_AW = 10;

   // log2 of the wide-to-narrow width ratio, i.e. number of lane-select address bits
   function automatic int unsigned ratio_log2(input int unsigned a_dw, input int unsigned b_dw);
      return $clog2(a_dw / b_dw);
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/asym_tdp_ram_oreg.sv
// Optional per-port read-data output register; collapses to a wire when EN is 0.
// Enabled from the top by defining ASYM_TDP_RAM_OUT_REG_EN.
module asym_tdp_ram_oreg #(
   parameter int unsigned W  = 16,
   parameter bit          EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (EN) begin : g_reg
         logic [W-1:0] q_r;

         always_ff @(posedge clk) begin
            if (!rst_n) q_r <= '0;
            else        q_r <= d;
         end

         assign q = q_r;
      end else begin : g_pass
         logic unused_ctl;
         assign unused_ctl = clk ^ rst_n;
         assign q = d;
      end
   endgenerate

endmodule

// File: rtl/asym_tdp_ram_rf.sv
// Asymmetric true-dual-port read-first RAM: wide port A, narrow port B, one shared array.
// Define ASYM_TDP_RAM_OUT_REG_EN to add one output register per port (read latency 2).
module asym_tdp_ram_rf
   import asym_tdp_ram_pkg::*;
#(
   parameter int unsigned PORTA_DW = DEF_PORTA_DW,
   parameter int unsigned PORTA_AW = DEF_PORTA_AW,
   parameter int unsigned PORTB_DW = DEF_PORTB_DW,
   parameter int unsigned PORTB_AW = DEF_PORTB_AW
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wea,
   input  logic [PORTA_AW-1:0] addra,
   input  logic [PORTA_DW-1:0] dina,
   output logic [PORTA_DW-1:0] douta,
   input  logic                web,
   input  logic [PORTB_AW-1:0] addrb,
   input  logic [PORTB_DW-1:0] dinb,
   output logic [PORTB_DW-1:0] doutb
);

   localparam int unsigned RATIO = PORTA_DW / PORTB_DW;
   localparam int unsigned L     = ratio_log2(PORTA_DW, PORTB_DW);
   localparam int unsigned DEPTH = 2 ** PORTA_AW;

`ifdef ASYM_TDP_RAM_OUT_REG_EN
   localparam bit OREG_EN = 1'b1;
`else
   localparam bit OREG_EN = 1'b0;
`endif

   generate
      if ((PORTA_DW * (2 ** PORTA_AW)) != (PORTB_DW * (2 ** PORTB_AW)) ||
          PORTA_DW < PORTB_DW || (PORTA_DW % PORTB_DW) != 0 || !is_pow2(RATIO)) begin : g_bad_cfg
         $error("asym_tdp_ram_rf: inconsistent port geometry");
      end
   endgenerate

   logic [PORTA_DW-1:0] mem [DEPTH];
   logic [PORTA_AW-1:0] b_word;
   logic [PORTB_AW-1:0] b_lane;
   int unsigned         lane_off;
   logic [PORTA_DW-1:0] rda;
   logic [PORTB_DW-1:0] rdb;

   // Narrow address splits into wide word index (upper bits) and lane (lower L bits)
   always_comb begin
      b_word   = PORTA_AW'(addrb >> L);
      b_lane   = addrb & PORTB_AW'(RATIO - 1);
      lane_off = 32'(b_lane) * PORTB_DW;
   end

   // Port A write is issued last so it wins any lane it shares with a port B write
   always_ff @(posedge clk) begin
      if (web) mem[b_word][lane_off +: PORTB_DW] <= dinb;
      if (wea) mem[addra] <= dina;
      if (!rst_n) begin
         rda <= '0;
         rdb <= '0;
      end else begin
         rda <= mem[addra];
         rdb <= mem[b_word][lane_off +: PORTB_DW];
      end
   end

   asym_tdp_ram_oreg #(.W(PORTA_DW), .EN(OREG_EN)) u_oreg_a (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rda),
      .q     (douta)
   );

   asym_tdp_ram_oreg #(.W(PORTB_DW), .EN(OREG_EN)) u_oreg_b (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rdb),
      .q     (doutb)
   );

endmodule

// File: tb/tb_asym_tdp_ram_rf.sv
// Scoreboard bench for asym_tdp_ram_rf: directed corner cases plus randomized dual-port traffic.
module tb_asym_tdp_ram_rf;

   localparam int unsigned ADW   = 16;
   localparam int unsigned AAW   = 8;
   localparam int unsigned BDW   = 4;
   localparam int unsigned BAW   = 10;
   localparam int unsigned RATIO = ADW / BDW;
   localparam int unsigned WORDS = 2 ** AAW;
`ifdef ASYM_TDP_RAM_OUT_REG_EN
   localparam int unsigned LAT = 2;
`else
   localparam int unsigned LAT = 1;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           wea, web;
   logic [AAW-1:0] addra;
   logic [ADW-1:0] dina, douta;
   logic [BAW-1:0] addrb;
   logic [BDW-1:0] dinb, doutb;

   always #5 clk = ~clk;

   asym_tdp_ram_rf dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .douta (douta),
      .web   (web),
      .addrb (addrb),
      .dinb  (dinb),
      .doutb (doutb)
   );

   typedef struct {
      logic [ADW-1:0] a;
      logic [BDW-1:0] b;
      bit             va;
      bit             vb;
   } exp_t;

   logic [ADW-1:0] model [WORDS];
   bit             known [WORDS];
   exp_t           sb [$];
   int             checks = 0;
   int             passed = 0;

   function automatic logic [BDW-1:0] model_b(input int unsigned k);
      logic [ADW-1:0] w;
      w = model[k / RATIO] >> ((k % RATIO) * BDW);
      return w[BDW-1:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One clock of stimulus; the expectation is the model content before this edge's writes
   task automatic step(input bit wa, input int unsigned aa, input logic [ADW-1:0] da,
                       input bit wb, input int unsigned ab, input logic [BDW-1:0] db,
                       input bit rst);
      exp_t           e;
      int unsigned    word, sh;
      logic [ADW-1:0] mask;
      rst_n = !rst;
      wea   = wa;  addra = AAW'(aa); dina = da;
      web   = wb;  addrb = BAW'(ab); dinb = db;
      e.a  = model[aa];
      e.va = known[aa];
      e.b  = model_b(ab);
      e.vb = known[ab / RATIO];
      @(posedge clk);
      if (rst) begin
         foreach (sb[i]) begin
            sb[i].a = '0; sb[i].b = '0; sb[i].va = 1'b1; sb[i].vb = 1'b1;
         end
         e.a = '0; e.b = '0; e.va = 1'b1; e.vb = 1'b1;
      end
      sb.push_back(e);
      if (wb) begin
         word = ab / RATIO;
         sh   = (ab % RATIO) * BDW;
         mask = ADW'(2 ** BDW - 1);
         model[word] = (model[word] & ~(mask << sh)) | (ADW'(db) << sh);
      end
      if (wa) begin
         model[aa] = da;
         known[aa] = 1'b1;
      end
      #1;
   endtask

   task automatic idle(input int unsigned aa, input int unsigned ab);
      step(1'b0, aa, '0, 1'b0, ab, '0, 1'b0);
   endtask

   // Monitor: each negedge, the oldest entry whose latency has elapsed is on the outputs
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() >= LAT) begin
         e = sb.pop_front();
         if (e.va) check("douta", 32'(douta), 32'(e.a));
         if (e.vb) check("doutb", 32'(doutb), 32'(e.b));
      end
   end

   initial begin
      foreach (known[i]) known[i] = 1'b0;
      foreach (model[i]) model[i] = '0;

      repeat (3) step(1'b0, 0, '0, 1'b0, 0, '0, 1'b1);

      for (int i = 0; i < int'(WORDS); i++)
         step(1'b1, i, ADW'($urandom), 1'b0, $urandom_range(BAW'(2 ** BAW - 1)), '0, 1'b0);

      // Wide write observed lane by lane
      step(1'b1, 0, 16'hAABC, 1'b0, 0, '0, 1'b0);
      for (int k = 0; k < 4; k++) idle(0, k);

      // Narrow writes assembled into one wide word
      for (int k = 0; k < 4; k++) step(1'b0, 16, '0, 1'b1, 64 + k, BDW'(k + 1), 1'b0);
      idle(16, 64);

      // Read-first on port A
      step(1'b1, 2, 16'hCCDE, 1'b0, 8, '0, 1'b0);
      step(1'b1, 2, 16'h1234, 1'b0, 8, '0, 1'b0);
      idle(2, 9);

      // Simultaneous overlapping writes: port A wins
      step(1'b1, 5, 16'hFFFF, 1'b1, 20, 4'h0, 1'b0);
      idle(5, 20);

      // Cross-port read of a word being written by port B
      step(1'b1, 5, 16'h0000, 1'b0, 0, '0, 1'b0);
      step(1'b0, 5, '0, 1'b1, 21, 4'h7, 1'b0);
      idle(5, 21);

      // Random traffic, biased towards same-word collisions
      for (int n = 0; n < 400; n++) begin
         int unsigned aa, ab;
         aa = $urandom_range(WORDS - 1);
         if ($urandom_range(1) == 1) ab = aa * RATIO + $urandom_range(RATIO - 1);
         else                        ab = $urandom_range(2 ** BAW - 1);
         step(1'($urandom), aa, ADW'($urandom), 1'($urandom), ab, BDW'($urandom), 1'b0);
      end

      // Reset mid-traffic with writes still landing in memory
      step(1'b1, 7, 16'h5A5A, 1'b1, 100, 4'h9, 1'b1);
      step(1'b0, 7, '0, 1'b0, 100, '0, 1'b1);
      idle(7, 100);
      idle(25, 28);
      for (int n = 0; n < 100; n++)
         step(1'($urandom), $urandom_range(WORDS - 1), ADW'($urandom),
              1'($urandom), $urandom_range(2 ** BAW - 1), BDW'($urandom), 1'b0);

      repeat (LAT + 2) idle(0, 0);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
